hub75_bcm_scheduler: RTL and testbench

Sequences HUB75 panel refresh using binary code modulation (BCM).
- Walks every row and every bit plane, commanding the fetch/shift datapath to load the next plane while the current plane is lit.
- Drives the panel row address, latch and output enable (OE) with exact per-bit on-times.
- Sits between the frame-buffer fetch/shift engine and the panel pins, replacing ad-hoc sequencing in the top-level FSM.

---
 rtl/hub75_bcm_scheduler.sv | 162 ++++++++++++++++
 tb/tb_hub75_bcm_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_bcm_scheduler.sv
// hub75_bcm_scheduler: binary-code-modulation refresh sequencer for HUB75 panels.
// Walks rows x bit planes, prefetching the next plane while the current one is
// lit, and drives row address, latch and OE with exact per-plane on-times.
// Optional build macro HUB75_DEADTIME_EN stretches BLANK to DEADTIME cycles so
// the row drivers settle before the latch.
module hub75_bcm_scheduler #(
   parameter int  BITS        = 8,
   parameter int  ROWS        = 32,
   parameter int  BASE_CYCLES = 4,
   parameter int  DEADTIME    = 2,
   localparam int ROW_W       = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int BIT_W       = (BITS > 1) ? $clog2(BITS) : 1
) (
   input  logic             sys_clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             fetch_busy,
   output logic             fetch_start,
   output logic [ROW_W-1:0] fetch_row,
   output logic [BIT_W-1:0] fetch_bit,
   output logic [ROW_W-1:0] row_addr,
   output logic             latch,
   output logic             oe_n,
   output logic             frame_done
);
   localparam int CNT_W = $clog2(BASE_CYCLES) + BITS + 1;
   // Blank counter is sized for the deadtime build so both builds share it.
   localparam int BLK_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
`ifdef HUB75_DEADTIME_EN
   localparam int BLANK_LEN = DEADTIME;
`else
   localparam int BLANK_LEN = 1;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_PREFETCH, S_PF_WAIT, S_BLANK, S_LATCH, S_SHOW, S_HOLD
   } state_e;

   state_e             state_q, state_d;
   logic [ROW_W-1:0]   cur_row_q, cur_row_d, nxt_row_q, nxt_row_d, row_addr_q, row_addr_d;
   logic [BIT_W-1:0]   cur_bit_q, cur_bit_d, nxt_bit_q, nxt_bit_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BLK_W-1:0]   blk_cnt_q, blk_cnt_d;
   logic               first_q, first_d;   // first SHOW cycle
   logic               fs_q, fs_d;         // fetch_start issued last cycle
   logic [ROW_W-1:0]   adv_row;
   logic [BIT_W-1:0]   adv_bit;
   logic               ready, last_plane, plane_done, advance;

   assign fetch_row   = nxt_row_q;
   assign fetch_bit   = nxt_bit_q;
   assign row_addr    = row_addr_q;
   assign fetch_start = (state_q == S_PREFETCH) || (state_q == S_SHOW && first_q);
   // The engine may not raise busy until the cycle after a start, so a shift
   // counts as finished only once that grace cycle has passed.
   assign ready       = !fetch_busy && !fs_q && !fetch_start;
   assign last_plane  = (cur_row_q == ROW_W'(ROWS - 1)) && (cur_bit_q == BIT_W'(BITS - 1));

   // Successor of the fetch pointer in (row, bit) scan order, wrapping to (0,0).
   always_comb begin
      adv_row = nxt_row_q;
      adv_bit = nxt_bit_q + 1'b1;
      if (nxt_bit_q == BIT_W'(BITS - 1)) begin
         adv_bit = '0;
         adv_row = (nxt_row_q == ROW_W'(ROWS - 1)) ? '0 : nxt_row_q + 1'b1;
      end
   end

   // Next-state, pointer and panel-strobe logic.
   always_comb begin
      state_d    = state_q;
      cur_row_d  = cur_row_q;
      cur_bit_d  = cur_bit_q;
      nxt_row_d  = nxt_row_q;
      nxt_bit_d  = nxt_bit_q;
      row_addr_d = row_addr_q;
      cnt_d      = cnt_q;
      blk_cnt_d  = blk_cnt_q;
      first_d    = 1'b0;
      fs_d       = fetch_start;
      latch      = 1'b0;
      oe_n       = 1'b1;
      frame_done = 1'b0;
      plane_done = 1'b0;
      advance    = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Let any shift left over from the last frame or a reset drain first.
            if (enable && !fetch_busy) begin
               state_d   = S_PREFETCH;
               nxt_row_d = '0;
               nxt_bit_d = '0;
            end
         end
         S_PREFETCH: state_d = S_PF_WAIT;
         S_PF_WAIT:  advance = ready;
         S_BLANK: begin
            if (blk_cnt_q == BLK_W'(BLANK_LEN - 1)) state_d = S_LATCH;
            else                                     blk_cnt_d = blk_cnt_q + 1'b1;
         end
         S_LATCH: begin
            latch   = 1'b1;
            cnt_d   = CNT_W'(BASE_CYCLES) << cur_bit_q;
            first_d = 1'b1;
            state_d = S_SHOW;
         end
         S_SHOW: begin
            oe_n = 1'b0;
            if (cnt_q == CNT_W'(1)) begin
               if (ready) plane_done = 1'b1;
               else       state_d    = S_HOLD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_HOLD:  plane_done = ready;
         default: state_d = S_IDLE;
      endcase
      // A plane has gone dark: either stop at frame end or roll straight on.
      if (plane_done) begin
         frame_done = last_plane;
         if (last_plane && !enable) state_d = S_IDLE;
         else                       advance = 1'b1;
      end
      if (advance) begin
         state_d    = S_BLANK;
         cur_row_d  = nxt_row_q;
         cur_bit_d  = nxt_bit_q;
         nxt_row_d  = adv_row;
         nxt_bit_d  = adv_bit;
         row_addr_d = nxt_row_q;
         blk_cnt_d  = '0;
      end
   end

   // State and pointer registers with synchronous reset.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cur_row_q  <= '0;
         cur_bit_q  <= '0;
         nxt_row_q  <= '0;
         nxt_bit_q  <= '0;
         row_addr_q <= '0;
         cnt_q      <= '0;
         blk_cnt_q  <= '0;
         first_q    <= 1'b0;
         fs_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_row_q  <= cur_row_d;
         cur_bit_q  <= cur_bit_d;
         nxt_row_q  <= nxt_row_d;
         nxt_bit_q  <= nxt_bit_d;
         row_addr_q <= row_addr_d;
         cnt_q      <= cnt_d;
         blk_cnt_q  <= blk_cnt_d;
         first_q    <= first_d;
         fs_q       <= fs_d;
      end
   end
endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
// Testbench for hub75_bcm_scheduler: small panel (3 planes x 2 rows, base 2),
// fetch engine model with fixed/random/stretched busy times, and a frame-order
// reference model checking every lit run, latch and fetch command.
`timescale 1ns/1ps
module tb_hub75_bcm_scheduler;
   localparam int BITS = 3, ROWS = 2, BASE = 2, DT_PARAM = 4;
`ifdef HUB75_DEADTIME_EN
   localparam int DT = DT_PARAM;
`else
   localparam int DT = 1;
`endif
   localparam int PLANES = BITS * ROWS;
   localparam int FRAME_LIT = ROWS * BASE * ((1 << BITS) - 1);

   logic       sys_clk = 1'b0;
   logic       rst, enable, fetch_busy;
   logic       fetch_start, latch, oe_n, frame_done;
   logic [0:0] fetch_row, row_addr;
   logic [1:0] fetch_bit;

   hub75_bcm_scheduler #(.BITS(BITS), .ROWS(ROWS), .BASE_CYCLES(BASE), .DEADTIME(DT_PARAM)) dut (
      .sys_clk(sys_clk), .rst(rst), .enable(enable), .fetch_busy(fetch_busy),
      .fetch_start(fetch_start), .fetch_row(fetch_row), .fetch_bit(fetch_bit),
      .row_addr(row_addr), .latch(latch), .oe_n(oe_n), .frame_done(frame_done));

   always #5 sys_clk = ~sys_clk;

   int tests = 0, fails = 0;
   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- fetch engine model ----------------
   int busy_len = 3;
   bit rand_busy = 1'b0;
   int long_row = -1, long_bit = -1, long_len = 0;

   initial begin
      fetch_busy = 1'b0;
      forever begin
         @(negedge sys_clk);
         if (fetch_start) begin
            int len;
            len = rand_busy ? int'($urandom_range(1, 12)) : busy_len;
            if (int'(fetch_row) == long_row && int'(fetch_bit) == long_bit) len = long_len;
            @(posedge sys_clk); #1 fetch_busy = 1'b1;
            repeat (len) @(posedge sys_clk);
            #1 fetch_busy = 1'b0;
         end
      end
   end

   // ---------------- reference model / monitor ----------------
   // Plane k of a frame is (row k/BITS, bit k%BITS), lit BASE<<bit cycles.
   int exp_idx, fetch_idx, run_len, run_row, run_plane, since_fd, since_row;
   int latch_cnt, lit_cnt, done_cnt;
   bit in_run, latch_seen, armed;
   logic [0:0] prev_row = 1'b0;

   always @(negedge sys_clk) begin
      if (rst) begin
         exp_idx = 0; fetch_idx = 0; in_run = 0; latch_seen = 0; armed = 0;
         since_fd = 0; latch_cnt = 0; lit_cnt = 0; done_cnt = 0;
      end else begin
         if (row_addr != prev_row) begin armed = 1; since_row = 0; end
         else if (armed) since_row++;
         if (fetch_start || !oe_n) armed = 0;
         if (latch) begin
            latch_cnt++;
            chk("latch_oe_n", int'(oe_n), 1);
            if (armed) begin chk("row_to_latch", since_row, DT); armed = 0; end
            latch_seen = 1;
         end
         if (!oe_n) begin
            lit_cnt++;
            if (!in_run) begin
               in_run = 1; run_len = 0; run_plane = exp_idx; run_row = int'(row_addr);
               chk("latch_before_run", int'(latch_seen), 1);
               latch_seen = 0;
               exp_idx = (exp_idx + 1) % PLANES;
               since_fd++;
            end
            run_len++;
         end else if (in_run) begin
            in_run = 0;
            chk("run_len", run_len, BASE << (run_plane % BITS));
            chk("run_row", run_row, run_plane / BITS);
         end
         if (fetch_start) begin
            chk("fetch_row", int'(fetch_row), fetch_idx / BITS);
            chk("fetch_bit", int'(fetch_bit), fetch_idx % BITS);
            fetch_idx = (fetch_idx + 1) % PLANES;
         end
         if (frame_done) begin
            done_cnt++;
            chk("frame_runs", since_fd, PLANES);
            since_fd = 0;
            if (!enable) fetch_idx = 0;   // restart re-prefetches (0,0)
         end
      end
      prev_row = row_addr;
   end

   // ---------------- vector table ----------------
   typedef struct {
      int busy_len;
      bit rnd;
      int frames;
      int exp_done;
      int exp_latch;
      int exp_lit;
   } vec_t;
   vec_t vecs[4];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1);
   end

   initial begin
      int n, k, hold_lit, hold_latch, snap_latch, snap_lit;
      bit found;
      int blen[4] = '{1, 3, 7, 0};
      for (int i = 0; i < 4; i++) begin
         vecs[i].busy_len  = blen[i];
         vecs[i].rnd       = (blen[i] == 0);
         vecs[i].frames    = 2 + i % 2;
         vecs[i].exp_done  = vecs[i].frames;
         vecs[i].exp_latch = vecs[i].frames * PLANES;
         vecs[i].exp_lit   = vecs[i].frames * FRAME_LIT;
      end

      rst = 1'b1; enable = 1'b0;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      chk("rst_oe_n", int'(oe_n), 1);
      chk("rst_latch", int'(latch), 0);
      chk("rst_fetch_start", int'(fetch_start), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_row_addr", int'(row_addr), 0);
      chk("rst_fetch_row", int'(fetch_row), 0);
      chk("rst_fetch_bit", int'(fetch_bit), 0);

      // Table: each vector starts from reset and runs whole frames.
      for (int i = 0; i < 4; i++) begin
         @(posedge sys_clk); #1 rst = 1'b1;
         busy_len = vecs[i].busy_len; rand_busy = vecs[i].rnd;
         repeat (2) @(posedge sys_clk);
         #1 rst = 1'b0; enable = 1'b1;
         n = 0;
         while (done_cnt < vecs[i].frames && n < 3000) begin @(posedge sys_clk); n++; end
         chk("vec_frames_done", done_cnt, vecs[i].exp_done);
         chk("vec_latches", latch_cnt, vecs[i].exp_latch);
         chk("vec_lit_cycles", lit_cnt, vecs[i].exp_lit);
      end
      rand_busy = 1'b0; busy_len = 3;

      // HOLD: shift of plane (0,2) takes 20 cycles, outlasting plane (0,1).
      long_row = 0; long_bit = 2; long_len = 20;
      found = 0; n = 0;
      while (!found && n < 400) begin
         @(negedge sys_clk); n++;
         found = fetch_start && fetch_row == 1'b0 && fetch_bit == 2'd2;
      end
      chk("hold_fetch_seen", int'(found), 1);
      n = 0;
      while (!oe_n && n < 20) begin @(negedge sys_clk); n++; end
      n = 0; hold_lit = 0; hold_latch = 0;
      while (fetch_busy && n < 60) begin
         n++;
         if (!oe_n) hold_lit++;
         if (latch) hold_latch++;
         @(negedge sys_clk);
      end
      chk("hold_cycles", n, long_len - (BASE << 1) + 1);
      chk("hold_oe_low", hold_lit, 0);
      chk("hold_latch", hold_latch, 0);
      k = 0;
      while (!latch && k < 20) begin @(negedge sys_clk); k++; end
      chk("latch_after_busy", k, DT + 1);
      long_row = -1;

      // Reset mid-SHOW.
      n = 0;
      while (oe_n && n < 200) begin @(negedge sys_clk); n++; end
      chk("show_reached", int'(oe_n), 0);
      @(posedge sys_clk); #1 rst = 1'b1;
      @(posedge sys_clk); @(negedge sys_clk);
      chk("mid_rst_oe_n", int'(oe_n), 1);
      chk("mid_rst_latch", int'(latch), 0);
      chk("mid_rst_fetch_start", int'(fetch_start), 0);
      chk("mid_rst_row_addr", int'(row_addr), 0);
      chk("mid_rst_fetch_row", int'(fetch_row), 0);
      chk("mid_rst_fetch_bit", int'(fetch_bit), 0);
      repeat (2) @(posedge sys_clk);
      #1 rst = 1'b0;
      found = 0; n = 0;
      while (!found && n < 60) begin @(negedge sys_clk); n++; found = fetch_start; end
      chk("restart_fetch", int'(found), 1);
      chk("restart_fetch_rb", int'({fetch_row, fetch_bit}), 0);

      // Enable drop during row 0: frame completes, then panel stays dark.
      found = 0; n = 0;
      while (!found && n < 200) begin
         @(negedge sys_clk); n++;
         found = fetch_start && fetch_row == 1'b0 && fetch_bit == 2'd1;
      end
      @(posedge sys_clk); #1 enable = 1'b0;
      found = 0; n = 0;
      while (!found && n < 500) begin @(negedge sys_clk); n++; found = frame_done; end
      chk("stop_frame_done", int'(found), 1);
      @(posedge sys_clk);
      snap_latch = latch_cnt; snap_lit = lit_cnt;
      repeat (60) @(posedge sys_clk);
      chk("stopped_latches", latch_cnt - snap_latch, 0);
      chk("stopped_lit", lit_cnt - snap_lit, 0);
      #1 enable = 1'b1;
      found = 0; n = 0;
      while (!found && n < 40) begin @(negedge sys_clk); n++; found = fetch_start; end
      chk("reenable_fetch", int'(found), 1);
      chk("reenable_fetch_rb", int'({fetch_row, fetch_bit}), 0);

      // Random busy times, checked plane by plane by the monitor.
      rand_busy = 1'b1;
      snap_latch = done_cnt; n = 0;
      while (done_cnt < snap_latch + 3 && n < 3000) begin @(posedge sys_clk); n++; end
      chk("rand_frames", done_cnt - snap_latch, 3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
